// File: rtl/rxll_frame_reader_if.sv
// Handshake bundle for the RX link-layer frame reader: FWFT FIFO head on one side,
// LocalLink source on the other. master = reader view, slave = FIFO/sink environment view.
interface rxll_frame_reader_if;
    logic [35:0] fifo_do;
    logic        fifo_empty;
    logic        fifo_eof_rdy;
    logic        fifo_rd_en;
    logic [31:0] ll_data;
    logic        ll_sof_n;
    logic        ll_eof_n;
    logic        ll_src_rdy_n;
    logic        ll_dst_rdy_n;

    modport master (
        input  fifo_do, fifo_empty, fifo_eof_rdy, ll_dst_rdy_n,
        output fifo_rd_en, ll_data, ll_sof_n, ll_eof_n, ll_src_rdy_n
    );

    modport slave (
        output fifo_do, fifo_empty, fifo_eof_rdy, ll_dst_rdy_n,
        input  fifo_rd_en, ll_data, ll_sof_n, ll_eof_n, ll_src_rdy_n
    );
endinterface

// File: rtl/rxll_frame_reader.sv
// SATA RX link-layer FIFO reader: unloads complete frames onto LocalLink, checks framing/length.
// Optional macro RXLL_READER_STATS_EN adds stat_frames/stat_errs counters.
module rxll_frame_reader #(
    parameter int C_MAX_WORDS = 2049,
    parameter int C_LEN_WIDTH = 12
) (
    input  logic                   rd_clk,
    input  logic                   rst,
    rxll_frame_reader_if.master    bus,
    output logic                   frame_done,
    output logic                   frame_err,
    output logic [C_LEN_WIDTH-1:0] frame_len
`ifdef RXLL_READER_STATS_EN
    ,
    output logic [15:0]            stat_frames,
    output logic [15:0]            stat_errs
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SOF   = 3'd1;
    localparam logic [2:0] S_XFER  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [C_LEN_WIDTH-1:0] MAX_CNT = C_LEN_WIDTH'(C_MAX_WORDS);

    logic [2:0]             state;
    logic                   out_vld;
    logic [C_LEN_WIDTH-1:0] cnt;
    logic [C_LEN_WIDTH-1:0] cnt_inc;
    logic                   err_flag;
    logic                   orphan;
    logic                   pop_ok;
    logic                   pop;
    logic                   done_fire;
    logic [31:0]            head_data;
    logic                   head_sof;
    logic                   head_err;
    logic                   head_eof;
    logic                   unused_rsvd;

    assign head_data   = bus.fifo_do[31:0];
    assign head_sof    = bus.fifo_do[32];
    assign head_err    = bus.fifo_do[33];
    assign head_eof    = bus.fifo_do[34];
    assign unused_rsvd = bus.fifo_do[35];

    assign pop_ok  = (state == S_SOF) || (state == S_XFER) || (state == S_DRAIN);
    assign pop     = pop_ok && !bus.fifo_empty && (!out_vld || !bus.ll_dst_rdy_n);
    assign cnt_inc = (cnt == MAX_CNT) ? cnt : cnt + 1'b1;

    // In DONE the output register can only hold the eof word; if it is already empty
    // (truncated eof accepted while draining) the frame completes straight away.
    assign done_fire = (state == S_DONE) && (!out_vld || !bus.ll_dst_rdy_n);

    assign bus.fifo_rd_en   = pop;
    assign bus.ll_src_rdy_n = !out_vld;

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state        <= S_IDLE;
            out_vld      <= 1'b0;
            bus.ll_data  <= '0;
            bus.ll_sof_n <= 1'b1;
            bus.ll_eof_n <= 1'b1;
            cnt          <= '0;
            err_flag     <= 1'b0;
            orphan       <= 1'b0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
            frame_len    <= '0;
        end else begin
            frame_done <= 1'b0;
            if (out_vld && !bus.ll_dst_rdy_n)
                out_vld <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (bus.fifo_eof_rdy && !bus.fifo_empty)
                        state <= S_SOF;
                end
                S_SOF: begin
                    if (pop) begin
                        if (head_sof) begin
                            out_vld      <= 1'b1;
                            bus.ll_data  <= head_data;
                            bus.ll_sof_n <= 1'b0;
                            bus.ll_eof_n <= !head_eof;
                            cnt          <= C_LEN_WIDTH'(1);
                            err_flag     <= err_flag | head_err;
                            state        <= head_eof ? S_DONE : S_XFER;
                        end else if (head_eof) begin
                            // A stray eof closes an orphan run: report it as an empty bad frame.
                            frame_done <= 1'b1;
                            frame_err  <= 1'b1;
                            frame_len  <= '0;
                            orphan     <= 1'b0;
                            err_flag   <= 1'b0;
                            state      <= S_IDLE;
                        end else begin
                            orphan <= 1'b1;
                        end
                    end
                end
                S_XFER: begin
                    if (pop) begin
                        out_vld      <= 1'b1;
                        bus.ll_data  <= head_data;
                        bus.ll_sof_n <= 1'b1;
                        cnt          <= cnt_inc;
                        err_flag     <= err_flag | head_err | head_sof;
                        if (head_eof) begin
                            bus.ll_eof_n <= 1'b0;
                            state        <= S_DONE;
                        end else if (cnt_inc == MAX_CNT) begin
                            bus.ll_eof_n <= 1'b0;
                            err_flag     <= 1'b1;
                            state        <= S_DRAIN;
                        end else begin
                            bus.ll_eof_n <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && head_eof)
                        state <= S_DONE;
                end
                S_DONE: begin
                    if (done_fire) begin
                        frame_done <= 1'b1;
                        frame_err  <= err_flag | orphan;
                        frame_len  <= cnt;
                        err_flag   <= 1'b0;
                        orphan     <= 1'b0;
                        cnt        <= '0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef RXLL_READER_STATS_EN
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            stat_frames <= '0;
            stat_errs   <= '0;
        end else if (frame_done) begin
            stat_frames <= stat_frames + 16'd1;
            stat_errs   <= stat_errs + {15'd0, frame_err};
        end
    end
`endif

endmodule

// File: tb/tb_rxll_frame_reader.sv
// Self-checking bench for rxll_frame_reader: FWFT FIFO model, stream-level frame model,
// per-cycle compare of accepted LocalLink words and frame status (also RXLL_READER_STATS_EN).
module tb_rxll_frame_reader;
    localparam int MAXW = 2049;
    localparam int LW   = 12;

    logic          rd_clk = 1'b0;
    logic          rst;
    logic          frame_done;
    logic          frame_err;
    logic [LW-1:0] frame_len;
`ifdef RXLL_READER_STATS_EN
    logic [15:0]   stat_frames;
    logic [15:0]   stat_errs;
`endif

    always #5 rd_clk = ~rd_clk;

    rxll_frame_reader_if bus ();

    rxll_frame_reader #(.C_MAX_WORDS(MAXW), .C_LEN_WIDTH(LW)) dut (
        .rd_clk     (rd_clk),
        .rst        (rst),
        .bus        (bus),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .frame_len  (frame_len)
`ifdef RXLL_READER_STATS_EN
        ,
        .stat_frames(stat_frames),
        .stat_errs  (stat_errs)
`endif
    );

    typedef struct packed {
        logic [31:0] data;
        logic        sof;
        logic        eof;
    } out_t;

    typedef struct packed {
        logic [LW-1:0] len;
        logic          err;
    } res_t;

    int          checks   = 0;
    int          failures = 0;
    logic [35:0] fifo_q[$];
    logic [35:0] stim_q[$];
    out_t        exp_out[$];
    res_t        exp_res[$];
    bit          toggle_rdy  = 1'b0;
    logic        pop_pending = 1'b0;
    int          seg_words   = 0;
    int          seg_done    = 0;
    logic [LW-1:0] last_len  = '0;
    logic        last_err    = 1'b0;
    int          stat_f_model = 0;
    int          stat_e_model = 0;

    function automatic logic [35:0] mk(input logic [31:0] d, input bit sof, input bit eof, input bit err);
        return {1'b0, eof, err, sof, d};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic refreshFifo();
        logic any_eof;
        any_eof = 1'b0;
        foreach (fifo_q[i]) any_eof |= fifo_q[i][34];
        bus.fifo_empty   = (fifo_q.size() == 0);
        bus.fifo_do      = (fifo_q.size() != 0) ? fifo_q[0] : 36'd0;
        bus.fifo_eof_rdy = any_eof;
    endtask

    // Stream-level model: walks the pushed words and lists the words the sink must see
    // and the status of every frame_done, then loads the words into the FIFO.
    task automatic applyStimulus();
        int          mode;
        int          cnt;
        bit          orphan;
        bit          err;
        logic [35:0] w;
        mode = 0; cnt = 0; orphan = 1'b0; err = 1'b0;
        foreach (stim_q[i]) begin
            w = stim_q[i];
            case (mode)
                0: begin
                    if (w[32]) begin
                        cnt = 1;
                        err = w[33];
                        exp_out.push_back(out_t'{data: w[31:0], sof: 1'b1, eof: w[34]});
                        if (w[34]) begin
                            exp_res.push_back(res_t'{len: LW'(cnt), err: err | orphan});
                            orphan = 1'b0; err = 1'b0;
                        end else begin
                            mode = 1;
                        end
                    end else begin
                        orphan = 1'b1;
                        if (w[34]) begin
                            exp_res.push_back(res_t'{len: '0, err: 1'b1});
                            orphan = 1'b0; err = 1'b0;
                        end
                    end
                end
                1: begin
                    cnt++;
                    err = err | w[33] | w[32];
                    if (w[34]) begin
                        exp_out.push_back(out_t'{data: w[31:0], sof: 1'b0, eof: 1'b1});
                        exp_res.push_back(res_t'{len: LW'(cnt), err: err | orphan});
                        orphan = 1'b0; err = 1'b0; mode = 0;
                    end else if (cnt == MAXW) begin
                        exp_out.push_back(out_t'{data: w[31:0], sof: 1'b0, eof: 1'b1});
                        err = 1'b1;
                        mode = 2;
                    end else begin
                        exp_out.push_back(out_t'{data: w[31:0], sof: 1'b0, eof: 1'b0});
                    end
                end
                default: begin
                    if (w[34]) begin
                        exp_res.push_back(res_t'{len: LW'(cnt), err: 1'b1});
                        orphan = 1'b0; err = 1'b0; mode = 0;
                    end
                end
            endcase
            fifo_q.push_back(w);
        end
        stim_q.delete();
        refreshFifo();
    endtask

    task automatic waitIdle(input string name, input int limit);
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < limit && !idle; c++) begin
            @(posedge rd_clk);
            idle = (exp_out.size() == 0) && (exp_res.size() == 0) && (fifo_q.size() == 0);
        end
        repeat (4) @(posedge rd_clk);
        #2;
        checks++;
        if (!idle) begin
            failures++;
            $display("[TB] FAIL %s_timeout: words pending %0d, results pending %0d, expected 0", name,
                     exp_out.size(), exp_res.size());
        end
    endtask

    task automatic startSegment();
        @(posedge rd_clk);
        #2;
        seg_words = 0;
        seg_done  = 0;
    endtask

    // FIFO pop and sink-ready driver, both moved just after the active edge.
    always @(posedge rd_clk) begin
        #1;
        if (pop_pending && fifo_q.size() != 0)
            void'(fifo_q.pop_front());
        bus.ll_dst_rdy_n = toggle_rdy ? ~bus.ll_dst_rdy_n : 1'b0;
        refreshFifo();
    end

    // Compare process: every accepted word and every frame_done against the model.
    always @(negedge rd_clk) begin
        out_t e;
        res_t r;
        pop_pending = bus.fifo_rd_en;
        if (!rst) begin
            if (!bus.ll_src_rdy_n && bus.ll_dst_rdy_n)
                checkOutput("rd_en_while_held", {63'd0, bus.fifo_rd_en}, 64'd0);
            if (!bus.ll_src_rdy_n && !bus.ll_dst_rdy_n) begin
                seg_words++;
                if (exp_out.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_word: got data %0h, expected no word", bus.ll_data);
                end else begin
                    e = exp_out.pop_front();
                    checkOutput("ll_data", {32'd0, bus.ll_data}, {32'd0, e.data});
                    checkOutput("ll_sof_n", {63'd0, bus.ll_sof_n}, {63'd0, !e.sof});
                    checkOutput("ll_eof_n", {63'd0, bus.ll_eof_n}, {63'd0, !e.eof});
                end
            end
            if (frame_done) begin
                seg_done++;
                last_len = frame_len;
                last_err = frame_err;
                stat_f_model++;
                if (frame_err) stat_e_model++;
                if (exp_res.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_frame_done: got len %0d, expected none", frame_len);
                end else begin
                    r = exp_res.pop_front();
                    checkOutput("frame_len", {52'd0, frame_len}, {52'd0, r.len});
                    checkOutput("frame_err", {63'd0, frame_err}, {63'd0, r.err});
                end
            end
        end
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_src_rdy_n"}, {63'd0, bus.ll_src_rdy_n}, 64'd1);
        checkOutput({tag, "_sof_n"}, {63'd0, bus.ll_sof_n}, 64'd1);
        checkOutput({tag, "_eof_n"}, {63'd0, bus.ll_eof_n}, 64'd1);
        checkOutput({tag, "_data"}, {32'd0, bus.ll_data}, 64'd0);
        checkOutput({tag, "_rd_en"}, {63'd0, bus.fifo_rd_en}, 64'd0);
        checkOutput({tag, "_frame_done"}, {63'd0, frame_done}, 64'd0);
        checkOutput({tag, "_frame_err"}, {63'd0, frame_err}, 64'd0);
        checkOutput({tag, "_frame_len"}, {52'd0, frame_len}, 64'd0);
`ifdef RXLL_READER_STATS_EN
        checkOutput({tag, "_stat_frames"}, {48'd0, stat_frames}, 64'd0);
        checkOutput({tag, "_stat_errs"}, {48'd0, stat_errs}, 64'd0);
`endif
    endtask

    task automatic checkSegment(input string tag, input int words, input int len, input bit err);
        checkOutput({tag, "_words"}, 64'(seg_words), 64'(words));
        checkOutput({tag, "_done_count"}, 64'(seg_done), 64'd1);
        checkOutput({tag, "_len"}, {52'd0, last_len}, 64'(len));
        checkOutput({tag, "_err"}, {63'd0, last_err}, {63'd0, err});
    endtask

    initial begin
        bool_init: begin
            rst = 1'b1;
            bus.ll_dst_rdy_n = 1'b0;
            refreshFifo();
        end
        repeat (3) @(posedge rd_clk);
        #2;
        rst = 1'b0;
        @(negedge rd_clk);
        checkResetValues("reset");

        // Test 1: 3-word frame, sink always ready.
        startSegment();
        stim_q.push_back(mk(32'hA000_0001, 1, 0, 0));
        stim_q.push_back(mk(32'hA000_0002, 0, 0, 0));
        stim_q.push_back(mk(32'hA000_0003, 0, 1, 0));
        applyStimulus();
        waitIdle("t1", 50);
        checkSegment("t1", 3, 3, 1'b0);

        // Test 2: same frame, sink ready toggling every cycle.
        toggle_rdy = 1'b1;
        startSegment();
        stim_q.push_back(mk(32'hB000_0001, 1, 0, 0));
        stim_q.push_back(mk(32'hB000_0002, 0, 0, 0));
        stim_q.push_back(mk(32'hB000_0003, 0, 1, 0));
        applyStimulus();
        waitIdle("t2", 80);
        checkSegment("t2", 3, 3, 1'b0);
        toggle_rdy = 1'b0;

        // Test 3: two orphans then a 1-word frame; orphan flag marks that frame bad.
        startSegment();
        stim_q.push_back(mk(32'hC000_0001, 0, 0, 0));
        stim_q.push_back(mk(32'hC000_0002, 0, 0, 0));
        stim_q.push_back(mk(32'hC000_0003, 1, 1, 0));
        applyStimulus();
        waitIdle("t3", 50);
        checkSegment("t3", 1, 1, 1'b1);

        // Test 3b: lone orphan eof word reports an empty bad frame.
        startSegment();
        stim_q.push_back(mk(32'hC100_0001, 0, 1, 0));
        applyStimulus();
        waitIdle("t3b", 50);
        checkSegment("t3b", 0, 0, 1'b1);

        // Test 4: 2100-word frame truncated to 2049 words, rest drained.
        startSegment();
        for (int i = 0; i < 2100; i++)
            stim_q.push_back(mk(32'hD000_0000 + 32'(i), i == 0, i == 2099, 0));
        applyStimulus();
        waitIdle("t4", 3000);
        checkSegment("t4", 2049, 2049, 1'b1);
        checkOutput("t4_fifo_left", 64'(fifo_q.size()), 64'd0);

        // Test 5: err bit on a middle word.
        startSegment();
        stim_q.push_back(mk(32'hE000_0001, 1, 0, 0));
        stim_q.push_back(mk(32'hE000_0002, 0, 0, 1));
        stim_q.push_back(mk(32'hE000_0003, 0, 0, 0));
        stim_q.push_back(mk(32'hE000_0004, 0, 1, 0));
        applyStimulus();
        waitIdle("t5", 50);
        checkSegment("t5", 4, 4, 1'b1);

`ifdef RXLL_READER_STATS_EN
        checkOutput("stat_frames", {48'd0, stat_frames}, 64'(stat_f_model));
        checkOutput("stat_errs", {48'd0, stat_errs}, 64'(stat_e_model));
        checkOutput("stat_frames_abs", {48'd0, stat_frames}, 64'd6);
        checkOutput("stat_errs_abs", {48'd0, stat_errs}, 64'd4);
`endif

        // Test 6: reset while transferring, then a clean frame.
        startSegment();
        for (int i = 0; i < 6; i++)
            stim_q.push_back(mk(32'hF000_0000 + 32'(i), i == 0, i == 5, 0));
        applyStimulus();
        begin
            bit reached;
            reached = 1'b0;
            for (int c = 0; c < 50 && !reached; c++) begin
                @(posedge rd_clk);
                reached = (seg_words >= 2);
            end
            checks++;
            if (!reached) begin
                failures++;
                $display("[TB] FAIL t6_reach_xfer: got %0d words, expected at least 2", seg_words);
            end
        end
        #2;
        rst = 1'b1;
        @(posedge rd_clk);
        #2;
        rst = 1'b0;
        fifo_q.delete();
        exp_out.delete();
        exp_res.delete();
        stat_f_model = 0;
        stat_e_model = 0;
        refreshFifo();
        @(negedge rd_clk);
        checkResetValues("t6_reset");

        startSegment();
        stim_q.push_back(mk(32'h1234_5678, 1, 0, 0));
        stim_q.push_back(mk(32'h9ABC_DEF0, 0, 1, 0));
        applyStimulus();
        waitIdle("t6", 50);
        checkSegment("t6", 2, 2, 1'b0);

`ifdef RXLL_READER_STATS_EN
        checkOutput("t6_stat_frames", {48'd0, stat_frames}, 64'd1);
        checkOutput("t6_stat_errs", {48'd0, stat_errs}, 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
